// File: rtl/control_unit_top.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_top
// Description : Decode-stage main decoder and branch resolver. Turns the opcode,
//               the R-type funct field and the upstream branch condition into
//               datapath control strobes with zero latency.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit_top (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code,
    input  logic [5:0] control_unit_funct,
    input  logic       eq_ne,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       ALUSrc_A,
    output logic [3:0] ALU_Func,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       se_ze,
    output logic [1:0] out_select,
    output logic       start_mult,
    output logic       mult_sign,
    output logic       output_branch,
    output logic [1:0] pc_source,
    output logic       mem_read
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_SLTIU = 6'b001011;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_XOR   = 6'b100110;
    localparam logic [5:0] c_FN_XNOR  = 6'b001100;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_SLTU  = 6'b101011;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam logic [5:0] c_FN_MULT  = 6'b011000;
    localparam logic [5:0] c_FN_MULTU = 6'b011001;

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_XOR  = 4'b0010;
    localparam logic [3:0] c_ALU_XNOR = 4'b0011;
    localparam logic [3:0] c_ALU_ADD  = 4'b0100;
    localparam logic [3:0] c_ALU_SUB  = 4'b1100;
    localparam logic [3:0] c_ALU_SLT  = 4'b1101;

    // Clock and reset exist only for pipeline port uniformity.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    always_comb begin
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        ALUSrc_A      = 1'b0;
        ALU_Func      = c_ALU_AND;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        se_ze         = 1'b0;
        out_select    = 2'b00;
        start_mult    = 1'b0;
        mult_sign     = 1'b0;
        output_branch = 1'b0;
        pc_source     = 2'b00;
        mem_read      = 1'b1;

        case (op_code)
            c_OP_RTYPE: begin
                // funct 000000 and unknown functs fall through as NOP
                case (control_unit_funct)
                    c_FN_ADD, c_FN_ADDU: begin
                        reg_write = 1'b1; reg_dst = 1'b1; ALU_Func = c_ALU_ADD;
                    end
                    c_FN_SUB, c_FN_SUBU: begin
                        reg_write = 1'b1; reg_dst = 1'b1; ALU_Func = c_ALU_SUB;
                    end
                    c_FN_AND: begin
                        reg_write = 1'b1; reg_dst = 1'b1; ALU_Func = c_ALU_AND;
                    end
                    c_FN_OR: begin
                        reg_write = 1'b1; reg_dst = 1'b1; ALU_Func = c_ALU_OR;
                    end
                    c_FN_XOR: begin
                        reg_write = 1'b1; reg_dst = 1'b1; ALU_Func = c_ALU_XOR;
                    end
                    c_FN_XNOR: begin
                        reg_write = 1'b1; reg_dst = 1'b1; ALU_Func = c_ALU_XNOR;
                    end
                    c_FN_SLT, c_FN_SLTU: begin
                        reg_write = 1'b1; reg_dst = 1'b1; ALU_Func = c_ALU_SLT;
                    end
                    c_FN_MFHI, c_FN_MFLO: begin
                        reg_write = 1'b1; reg_dst = 1'b1; out_select = 2'b11;
                    end
                    c_FN_MULT, c_FN_MULTU: begin
                        reg_write  = 1'b1;
                        reg_dst    = 1'b1;
                        out_select = 2'b10;
                        start_mult = 1'b1;
                        mult_sign  = (control_unit_funct == c_FN_MULT);
                    end
                    default: ;
                endcase
            end
            c_OP_J: begin
                mem_to_reg = 1'b1;
                pc_source  = 2'b10;
            end
            c_OP_BEQ, c_OP_BNE: begin
                // Condition is resolved upstream for both branch flavours.
                mem_to_reg    = 1'b1;
                output_branch = eq_ne;
                pc_source     = eq_ne ? 2'b01 : 2'b00;
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_LW: begin
                reg_write = 1'b1; ALUSrc_A = 1'b1; ALU_Func = c_ALU_ADD; se_ze = 1'b1;
            end
            c_OP_SLTI, c_OP_SLTIU: begin
                reg_write = 1'b1; ALUSrc_A = 1'b1; ALU_Func = c_ALU_SLT; se_ze = 1'b1;
            end
            c_OP_ANDI: begin
                reg_write = 1'b1; ALUSrc_A = 1'b1; ALU_Func = c_ALU_AND;
            end
            c_OP_ORI: begin
                reg_write = 1'b1; ALUSrc_A = 1'b1; ALU_Func = c_ALU_OR;
            end
            c_OP_XORI: begin
                reg_write = 1'b1; ALUSrc_A = 1'b1; ALU_Func = c_ALU_XOR;
            end
            c_OP_LUI: begin
                reg_write = 1'b1; ALUSrc_A = 1'b1; out_select = 2'b01;
            end
            c_OP_SW: begin
                ALUSrc_A = 1'b1; ALU_Func = c_ALU_ADD; mem_write = 1'b1; se_ze = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit_top
// Description : Scoreboard bench for control_unit_top with a table-driven model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit_top;

    logic       clk;
    logic       rst;
    logic [5:0] op_code;
    logic [5:0] control_unit_funct;
    logic       eq_ne;
    logic       reg_write, reg_dst, ALUSrc_A, mem_write, mem_to_reg, se_ze;
    logic       start_mult, mult_sign, output_branch, mem_read;
    logic [3:0] ALU_Func;
    logic [1:0] out_select, pc_source;

    control_unit_top dut (
        .clk(clk), .rst(rst), .op_code(op_code), .control_unit_funct(control_unit_funct),
        .eq_ne(eq_ne), .reg_write(reg_write), .reg_dst(reg_dst), .ALUSrc_A(ALUSrc_A),
        .ALU_Func(ALU_Func), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .se_ze(se_ze),
        .out_select(out_select), .start_mult(start_mult), .mult_sign(mult_sign),
        .output_branch(output_branch), .pc_source(pc_source), .mem_read(mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] exp;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        eq;
    } sb_item_t;

    sb_item_t    sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [17:0] rtype_tbl [64];
    logic [17:0] op_tbl    [64];

    // Vector order: rw rd asrc alu[3:0] mw m2r se os[1:0] sm ms br pc[1:0] mem_read
    function automatic logic [17:0] vec(input logic rw, input logic rd, input logic as,
                                        input logic [3:0] alu, input logic mw, input logic m2r,
                                        input logic se, input logic [1:0] os, input logic sm,
                                        input logic ms, input logic br, input logic [1:0] pc);
        return {rw, rd, as, alu, mw, m2r, se, os, sm, ms, br, pc, 1'b1};
    endfunction

    task automatic build_tables();
        logic [17:0] nop;
        nop = vec(0,0,0,4'h0,0,0,0,2'b00,0,0,0,2'b00);
        for (int i = 0; i < 64; i++) begin
            rtype_tbl[i] = nop;
            op_tbl[i]    = nop;
        end
        rtype_tbl[6'o40] = vec(1,1,0,4'b0100,0,0,0,2'b00,0,0,0,2'b00); // ADD
        rtype_tbl[6'o41] = vec(1,1,0,4'b0100,0,0,0,2'b00,0,0,0,2'b00); // ADDU
        rtype_tbl[6'o42] = vec(1,1,0,4'b1100,0,0,0,2'b00,0,0,0,2'b00); // SUB
        rtype_tbl[6'o43] = vec(1,1,0,4'b1100,0,0,0,2'b00,0,0,0,2'b00); // SUBU
        rtype_tbl[6'o44] = vec(1,1,0,4'b0000,0,0,0,2'b00,0,0,0,2'b00); // AND
        rtype_tbl[6'o45] = vec(1,1,0,4'b0001,0,0,0,2'b00,0,0,0,2'b00); // OR
        rtype_tbl[6'o46] = vec(1,1,0,4'b0010,0,0,0,2'b00,0,0,0,2'b00); // XOR
        rtype_tbl[6'o14] = vec(1,1,0,4'b0011,0,0,0,2'b00,0,0,0,2'b00); // XNOR
        rtype_tbl[6'o52] = vec(1,1,0,4'b1101,0,0,0,2'b00,0,0,0,2'b00); // SLT
        rtype_tbl[6'o53] = vec(1,1,0,4'b1101,0,0,0,2'b00,0,0,0,2'b00); // SLTU
        rtype_tbl[6'o20] = vec(1,1,0,4'b0000,0,0,0,2'b11,0,0,0,2'b00); // MFHI
        rtype_tbl[6'o22] = vec(1,1,0,4'b0000,0,0,0,2'b11,0,0,0,2'b00); // MFLO
        rtype_tbl[6'o30] = vec(1,1,0,4'b0000,0,0,0,2'b10,1,1,0,2'b00); // MULT
        rtype_tbl[6'o31] = vec(1,1,0,4'b0000,0,0,0,2'b10,1,0,0,2'b00); // MULTU
        op_tbl[6'o02] = vec(0,0,0,4'b0000,0,1,0,2'b00,0,0,0,2'b10);    // J
        op_tbl[6'o10] = vec(1,0,1,4'b0100,0,0,1,2'b00,0,0,0,2'b00);    // ADDI
        op_tbl[6'o11] = op_tbl[6'o10];                                 // ADDIU
        op_tbl[6'o12] = vec(1,0,1,4'b1101,0,0,1,2'b00,0,0,0,2'b00);    // SLTI
        op_tbl[6'o13] = op_tbl[6'o12];                                 // SLTIU
        op_tbl[6'o14] = vec(1,0,1,4'b0000,0,0,0,2'b00,0,0,0,2'b00);    // ANDI
        op_tbl[6'o15] = vec(1,0,1,4'b0001,0,0,0,2'b00,0,0,0,2'b00);    // ORI
        op_tbl[6'o16] = vec(1,0,1,4'b0010,0,0,0,2'b00,0,0,0,2'b00);    // XORI
        op_tbl[6'o17] = vec(1,0,1,4'b0000,0,0,0,2'b01,0,0,0,2'b00);    // LUI
        op_tbl[6'o43] = op_tbl[6'o10];                                 // LW
        op_tbl[6'o53] = vec(0,0,1,4'b0100,1,0,1,2'b00,0,0,0,2'b00);    // SW
    endtask

    function automatic logic [17:0] model(input logic [5:0] op, input logic [5:0] fn,
                                          input logic eq);
        if (op == 6'o00)
            return rtype_tbl[fn];
        if (op == 6'o04 || op == 6'o05)
            return vec(0,0,0,4'b0000,0,1,0,2'b00,0,0,eq, eq ? 2'b01 : 2'b00);
        return op_tbl[op];
    endfunction

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                         input logic r);
        sb_item_t it;
        @(posedge clk);
        #1;
        op_code            = op;
        control_unit_funct = fn;
        eq_ne              = eq;
        rst                = r;
        it.exp = model(op, fn, eq);
        it.op  = op;
        it.fn  = fn;
        it.eq  = eq;
        sb_q.push_back(it);
    endtask

    // Monitor: the decode is combinational, so the output is presented every
    // cycle; sample on the falling edge, mid-cycle after the drive.
    always @(negedge clk) begin
        sb_item_t    it;
        logic [17:0] act;
        if (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = {reg_write, reg_dst, ALUSrc_A, ALU_Func, mem_write, mem_to_reg, se_ze,
                   out_select, start_mult, mult_sign, output_branch, pc_source, mem_read};
            n_checks++;
            if (act === it.exp)
                n_pass++;
            else
                $display("FAIL decode op=%b fn=%b eq=%b: got %b expected %b",
                         it.op, it.fn, it.eq, act, it.exp);
        end
    end

    logic [5:0] interesting [20];

    initial begin
        rst = 1'b1; op_code = 6'h00; control_unit_funct = 6'h00; eq_ne = 1'b0;
        build_tables();
        interesting = '{6'o00,6'o00,6'o00,6'o00,6'o02,6'o04,6'o05,6'o10,6'o11,6'o12,
                        6'o13,6'o14,6'o15,6'o16,6'o17,6'o43,6'o53,6'o77,6'o01,6'o03};

        // Reset-time vectors: NOP regardless of reset
        issue(6'o00, 6'o00, 1'b0, 1'b1);
        issue(6'o77, 6'o40, 1'b1, 1'b1);
        // R-type sweep
        issue(6'o00, 6'o40, 1'b0, 1'b0);
        issue(6'o00, 6'o42, 1'b0, 1'b0);
        issue(6'o00, 6'o14, 1'b0, 1'b0);
        issue(6'o00, 6'o52, 1'b1, 1'b0);
        issue(6'o00, 6'o30, 1'b0, 1'b0);
        issue(6'o00, 6'o31, 1'b0, 1'b0);
        issue(6'o00, 6'o20, 1'b0, 1'b0);
        issue(6'o00, 6'o22, 1'b0, 1'b0);
        issue(6'o00, 6'o00, 1'b1, 1'b0);
        // Branches and jump
        issue(6'o04, 6'o40, 1'b1, 1'b0);
        issue(6'o04, 6'o40, 1'b0, 1'b0);
        issue(6'o05, 6'o00, 1'b1, 1'b0);
        issue(6'o05, 6'o00, 1'b0, 1'b0);
        issue(6'o02, 6'o30, 1'b1, 1'b0);
        // Immediates, loads, stores, illegal
        issue(6'o10, 6'o00, 1'b0, 1'b0);
        issue(6'o12, 6'o00, 1'b0, 1'b0);
        issue(6'o14, 6'o40, 1'b0, 1'b0);
        issue(6'o15, 6'o00, 1'b0, 1'b0);
        issue(6'o16, 6'o00, 1'b0, 1'b0);
        issue(6'o17, 6'o00, 1'b1, 1'b0);
        issue(6'o43, 6'o00, 1'b0, 1'b0);
        issue(6'o53, 6'o00, 1'b0, 1'b0);
        issue(6'o77, 6'o00, 1'b1, 1'b0);
        issue(6'o77, 6'o00, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            if ($urandom_range(1, 0) == 1)
                op = interesting[$urandom_range(19, 0)];
            else
                op = 6'($urandom_range(63, 0));
            fn = 6'($urandom_range(63, 0));
            if (op == 6'o00 && $urandom_range(1, 0) == 1)
                fn = {1'b1, 1'b0, 4'($urandom_range(11, 0))};
            issue(op, fn, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        for (int t = 0; t < 10 && sb_q.size() > 0; t++)
            @(posedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d items left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
